// File: rtl/dsky_key_channel_if.sv
// dsky_key_channel_if: chan 15 keypad/CPU bundle; master drives key/read/ack/clear, slave returns data, KEYRUPT, avail, overflow
interface dsky_key_channel_if;
  logic        key_down;
  logic [4:0]  key_code;
  logic        rd_strobe;
  logic        keyrupt_ack;
  logic        ovf_clr;
  logic [15:0] chan15_data;
  logic        keyrupt_req;
  logic        key_avail;
  logic        key_ovf;
  modport master (
    output key_down, key_code, rd_strobe, keyrupt_ack, ovf_clr,
    input  chan15_data, keyrupt_req, key_avail, key_ovf
  );
  modport slave (
    input  key_down, key_code, rd_strobe, keyrupt_ack, ovf_clr,
    output chan15_data, keyrupt_req, key_avail, key_ovf
  );
endinterface

// File: rtl/dsky_key_channel.sv
// dsky_key_channel: debounces DSKY keys, FIFOs valid keycodes, raises KEYRUPT; ports clk, reset, bus (slave: key_down/key_code/rd_strobe/keyrupt_ack/ovf_clr in, chan15_data/keyrupt_req/key_avail/key_ovf out)
module dsky_key_channel #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int CNT_W           = 8
) (
  input logic           clk,
  input logic           reset,
  dsky_key_channel_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       code_q, code_d;
  logic [4:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      count_q, count_d;
  logic [15:0]      data_q, data_d;
  logic             avail_q, avail_d, req_q, req_d, ovf_q, ovf_d, ack_q, ack_d;
  logic             push, pop, full, push_ok;
  logic [4:0]       head;
  function automatic logic code_ok(input logic [4:0] c);
    return (c >= 5'd1 && c <= 5'd9) ||
           (c inside {5'b10000, 5'b10001, 5'b10010, 5'b11001, 5'b11010,
                      5'b11011, 5'b11100, 5'b11110, 5'b11111});
  endfunction
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    push    = 1'b0;
    case (state_q)
      IDLE:
        if (bus.key_down && code_ok(bus.key_code)) begin
          code_d  = bus.key_code;
          cnt_d   = CNT_W'(1);
          state_d = PRESS_DB;
        end
      PRESS_DB:
        if (!bus.key_down || bus.key_code != code_q) state_d = IDLE;
        else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
          push    = 1'b1;
          state_d = HELD;
        end else cnt_d = cnt_q + CNT_W'(1);
      HELD:
        if (!bus.key_down) begin
          cnt_d   = CNT_W'(1);
          state_d = REL_DB;
        end
      default:
        if (bus.key_down) state_d = HELD;
        else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) state_d = IDLE;
        else cnt_d = cnt_q + CNT_W'(1);
    endcase
  end
  // A push into a full FIFO still lands when the same cycle pops the head.
  always_comb begin
    pop     = bus.rd_strobe && count_q != '0;
    full    = count_q == (AW+1)'(FIFO_DEPTH);
    push_ok = push && (!full || pop);
    wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
    rd_d    = pop ? rd_q + AW'(1) : rd_q;
    count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    head    = (push_ok && rd_d == wr_q) ? code_q : mem_q[rd_d];
    avail_d = count_d != '0;
    data_d  = avail_d ? {11'b0, head} : 16'd0;
    ovf_d   = (push && full && !pop) || (ovf_q && !bus.ovf_clr);
    ack_d   = bus.rd_strobe ? 1'b0 : bus.keyrupt_ack ? 1'b1 : ack_q;
    req_d   = avail_d && !ack_d;
  end
  always_ff @(posedge clk)
    if (push_ok && !reset) mem_q[wr_q] <= code_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      data_q  <= '0;
      avail_q <= 1'b0;
      req_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      data_q  <= data_d;
      avail_q <= avail_d;
      req_q   <= req_d;
      ovf_q   <= ovf_d;
      ack_q   <= ack_d;
    end
  end
  assign bus.chan15_data = data_q;
  assign bus.key_avail   = avail_q;
  assign bus.keyrupt_req = req_q;
  assign bus.key_ovf     = ovf_q;
endmodule

// File: tb/tb_dsky_key_channel.sv
// tb_dsky_key_channel: randomized and directed checks of dsky_key_channel against a queue-based reference model
module tb_dsky_key_channel;
  localparam int DB = 16;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  dsky_key_channel_if bus ();
  dsky_key_channel #(.DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  logic [4:0] vlist [19] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                             5'd16, 5'd17, 5'd18, 5'd25, 5'd26, 5'd27, 5'd28, 5'd30, 5'd31, 5'd31};
  logic [4:0] q [$];
  int         run, low_run;
  bit         held, m_ovf, m_ack;
  logic [4:0] rcode;
  function automatic bit is_valid(input logic [4:0] c);
    foreach (vlist[i]) if (vlist[i] == c) return 1'b1;
    return 1'b0;
  endfunction
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input logic kd, input logic [4:0] kc, input logic rd, input logic ack, input logic clr);
    bit push;
    bit do_pop;
    bus.key_down = kd;
    bus.key_code = kc;
    bus.rd_strobe = rd;
    bus.keyrupt_ack = ack;
    bus.ovf_clr = clr;
    @(posedge clk);
    if (reset) begin
      q.delete();
      run = 0; low_run = 0; held = 0; m_ovf = 0; m_ack = 0;
    end else begin
      push = 0;
      if (!held) begin
        // A press counts while the same valid code is held; the sample that completes DB+1 stable samples pushes.
        if (kd && is_valid(kc) && (run == 0 || kc == rcode)) begin
          if (run == 0) rcode = kc;
          run++;
          if (run == DB + 1) begin
            push = 1; held = 1; run = 0; low_run = 0;
          end
        end else run = 0;
      end else if (!kd) begin
        low_run++;
        if (low_run == DB + 1) begin
          held = 0; low_run = 0;
        end
      end else low_run = 0;
      do_pop = rd && q.size() > 0;
      if (do_pop) void'(q.pop_front());
      if (clr) m_ovf = 0;
      if (push) begin
        if (q.size() < DEPTH) q.push_back(rcode);
        else m_ovf = 1;
      end
      if (rd) m_ack = 0;
      else if (ack) m_ack = 1;
    end
    #1;
    chk("data", bus.chan15_data, q.size() > 0 ? {11'b0, q[0]} : 16'd0);
    chk("avail", {15'b0, bus.key_avail}, {15'b0, q.size() > 0});
    chk("req", {15'b0, bus.keyrupt_req}, {15'b0, q.size() > 0 && !m_ack});
    chk("ovf", {15'b0, bus.key_ovf}, {15'b0, m_ovf});
  endtask
  task automatic press(input logic [4:0] c, input int hi, input int lo);
    for (int i = 0; i < hi; i++) cyc(1'b1, c, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < lo; i++) cyc(1'b0, c, 1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    bus.key_down = 0; bus.key_code = 0; bus.rd_strobe = 0; bus.keyrupt_ack = 0; bus.ovf_clr = 0;
    reset = 1;
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 5'd17, 1'b1, 1'b1, 1'b0);
    reset = 0;
    chk("rst_data", bus.chan15_data, 16'd0);
    chk("rst_avail", {15'b0, bus.key_avail}, 16'd0);
    // clean VERB press
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 5'b10001, 1'b0, 1'b0, 1'b0);
      if (i == 15) chk("verb_early", {15'b0, bus.key_avail}, 16'd0);
      if (i == 16) chk("verb_push", bus.chan15_data, 16'h0011);
    end
    chk("verb_req", {15'b0, bus.keyrupt_req}, 16'd1);
    press(5'b10001, 0, 20);
    cyc(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("ack_req", {15'b0, bus.keyrupt_req}, 16'd0);
    cyc(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("read_avail", {15'b0, bus.key_avail}, 16'd0);
    // bouncing press then bouncing release
    for (int i = 0; i < 30; i++) cyc(((i / 3) % 2) == 0, 5'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) cyc(1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) cyc(((i / 3) % 2) == 1, 5'd5, 1'b0, 1'b0, 1'b0);
    press(5'd5, 0, 20);
    chk("bounce_one", bus.chan15_data, 16'h0005);
    cyc(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    chk("bounce_empty", {15'b0, bus.key_avail}, 16'd0);
    // invalid codes
    press(5'b00000, 40, 20);
    press(5'b01010, 40, 20);
    chk("invalid", bus.chan15_data, 16'd0);
    // overflow with five keys
    press(5'd1, 20, 20); press(5'd2, 20, 20); press(5'd3, 20, 20); press(5'd4, 20, 20); press(5'd31, 20, 20);
    chk("ovf_set", {15'b0, bus.key_ovf}, 16'd1);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_order", bus.chan15_data, 16'(k));
      cyc(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    end
    cyc(1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", {15'b0, bus.key_ovf}, 16'd0);
    // full FIFO, push coincident with read
    press(5'd6, 20, 20); press(5'd7, 20, 20); press(5'd8, 20, 20); press(5'd9, 20, 20);
    for (int i = 0; i < 20; i++) cyc(1'b1, 5'd16, i == 16, 1'b0, 1'b0);
    press(5'd16, 0, 20);
    chk("full_pp_ovf", {15'b0, bus.key_ovf}, 16'd0);
    chk("full_pp_head", bus.chan15_data, 16'h0007);
    for (int i = 0; i < 6; i++) cyc(1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    // reset in the middle of a press
    for (int i = 0; i < 10; i++) cyc(1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    reset = 1;
    cyc(1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    reset = 0;
    press(5'd3, 5, 20);
    chk("rst_nopush", {15'b0, bus.key_avail}, 16'd0);
    press(5'd3, 20, 20);
    chk("rst_anew", bus.chan15_data, 16'h0003);
    // randomized episodes
    for (int e = 0; e < 150; e++) begin
      logic [4:0] c;
      int hi, lo;
      bit bnc;
      c = ($urandom_range(0, 4) == 0) ? 5'($urandom) : vlist[$urandom_range(0, 18)];
      hi = $urandom_range(3, 40);
      lo = $urandom_range(3, 30);
      bnc = $urandom_range(0, 3) == 0;
      for (int i = 0; i < hi + lo; i++) begin
        logic kd, rd, ack;
        kd = (i < hi) ^ (bnc && $urandom_range(0, 7) == 0);
        if ($urandom_range(0, 40) == 0) c = vlist[$urandom_range(0, 18)];
        rd = $urandom_range(0, 9) == 0;
        ack = !rd && $urandom_range(0, 5) == 0;
        reset = $urandom_range(0, 300) == 0;
        cyc(kd, c, rd, ack, $urandom_range(0, 25) == 0);
        reset = 0;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
